// File: rtl/neuro_step_sequencer.sv
// Step controller for the digit-detector pipeline: walks steps 1..LAST_STEP, issuing
// load/compute start pulses, waiting for the matching done pulse, with a per-step watchdog.
module neuro_step_sequencer #(
   parameter int STEP_W    = 5,
   parameter int LAST_STEP = 15,
   parameter int TMO_W     = 16,
   parameter int TMO_LIMIT = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              GO,
   input  logic              load_done,
   input  logic              comp_done,
   output logic [STEP_W-1:0] step_out,
   output logic              load_start,
   output logic              comp_start,
   output logic              nextstep,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_ADVANCE,
      S_FINISH,
      S_ERROR
   } state_t;

   state_t            state_q, state_nx;
   logic [STEP_W-1:0] step_q, step_nx;
   logic [TMO_W-1:0]  wd_q, wd_nx;
   logic              is_load;
   logic              match_done;

   // Step 1 (picture load) and every even step are loads; odd steps from 3 are computes.
   assign is_load    = (step_q == STEP_W'(1)) || !step_q[0];
   assign match_done = is_load ? load_done : comp_done;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_nx;
         step_q  <= step_nx;
         wd_q    <= wd_nx;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a value
   // unassigned and no latch is inferred.
   always_comb begin
      state_nx   = state_q;
      step_nx    = step_q;
      wd_nx      = wd_q;
      load_start = 1'b0;
      comp_start = 1'b0;
      nextstep   = 1'b0;

      unique case (state_q)
         S_IDLE, S_FINISH: begin
            if (GO) begin
               state_nx = S_START;
               step_nx  = STEP_W'(1);
            end
         end
         S_START: begin
            load_start = is_load;
            comp_start = !is_load;
            wd_nx      = '0;
            state_nx   = S_WAIT;
         end
         S_WAIT: begin
            // A matching done on the watchdog's final cycle takes precedence over the timeout.
            if (match_done) begin
               state_nx = (step_q == STEP_W'(LAST_STEP)) ? S_FINISH : S_ADVANCE;
            end else begin
               wd_nx = wd_q + TMO_W'(1);
               if (wd_q == TMO_W'(TMO_LIMIT - 1)) state_nx = S_ERROR;
            end
         end
         S_ADVANCE: begin
            nextstep = 1'b1;
            step_nx  = step_q + STEP_W'(1);
            state_nx = S_START;
         end
         S_ERROR: begin
            state_nx = S_ERROR;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   assign step_out = step_q;
   assign busy     = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_ADVANCE);
   assign done     = (state_q == S_FINISH);
   assign error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_neuro_step_sequencer.sv
// Directed and randomized bench for neuro_step_sequencer; expectations come from the
// step-class and latency rules evaluated per step.
module tb_neuro_step_sequencer;

   localparam int STEP_W = 5;
   localparam int LAST   = 15;
   localparam int TMO    = 20;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              go = 1'b0;
   logic              load_done = 1'b0;
   logic              comp_done = 1'b0;
   logic [STEP_W-1:0] step_out;
   logic              load_start, comp_start, nextstep, busy, done, error;

   int errors = 0;
   int checks = 0;
   int ns_count = 0;
   bit mon_en = 1'b0;

   neuro_step_sequencer #(
      .STEP_W   (STEP_W),
      .LAST_STEP(LAST),
      .TMO_W    (16),
      .TMO_LIMIT(TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .GO        (go),
      .load_done (load_done),
      .comp_done (comp_done),
      .step_out  (step_out),
      .load_start(load_start),
      .comp_start(comp_start),
      .nextstep  (nextstep),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulses are exclusive at every cycle once out of reset; nextstep pulses are tallied.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         check("pulse_exclusive",
               32'((load_start && comp_start) || (load_start && nextstep) ||
                   (comp_start && nextstep)), 0);
         if (nextstep === 1'b1) ns_count++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit exp_is_load(input int s);
      return (s == 1) || (s % 2 == 0);
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_step"}, step_out, 0);
      check({tag, "_pulses"}, {load_start, comp_start, nextstep}, 0);
      check({tag, "_flags"}, {busy, done, error}, 0);
   endtask

   // Entered in the START cycle of step s; answers with the matching done in WAIT cycle d.
   // With decoy set, the wrong done is pulsed in WAIT cycle 1 and both dones in cycle d.
   task automatic run_step(input int s, input int d, input bit decoy);
      bit ld;
      ld = exp_is_load(s);
      check("start_step", step_out, s);
      check("start_load", load_start, 32'(ld));
      check("start_comp", comp_start, 32'(!ld));
      check("start_busy", {busy, done, error, nextstep}, 4'b1000);
      tick();
      for (int i = 1; i < d; i++) begin
         if (decoy && i == 1) begin
            load_done = !ld;
            comp_done = ld;
         end
         check("wait_step", step_out, s);
         check("wait_pulses", {load_start, comp_start, nextstep, error}, 0);
         tick();
         load_done = 1'b0;
         comp_done = 1'b0;
      end
      check("wait_last", {busy, error, nextstep}, 3'b100);
      load_done = ld | decoy;
      comp_done = !ld | decoy;
      tick();
      load_done = 1'b0;
      comp_done = 1'b0;
      if (s < LAST) begin
         check("adv_nextstep", nextstep, 1);
         check("adv_step", step_out, s);
         check("adv_starts", {load_start, comp_start, error}, 0);
         tick();
      end else begin
         check("fin_flags", {done, busy, error, nextstep}, 4'b1000);
         check("fin_step", step_out, LAST);
      end
   endtask

   task automatic go_pulse();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int ns_before;
      int d;
      bit dec;

      // Reset state
      tick();
      tick();
      mon_en = 1'b1;
      check_idle("reset");
      rst = 1'b0;
      tick();
      check_idle("idle");

      // Single GO pulse, then a full run with done 5 cycles after each start
      ns_before = ns_count;
      go_pulse();
      check("go_step", step_out, 1);
      check("go_load", load_start, 1);
      check("go_comp", comp_start, 0);
      check("go_busy", busy, 1);
      for (int s = 1; s <= LAST; s++) run_step(s, 5, 1'b0);
      check("nextstep_count", ns_count - ns_before, LAST - 1);
      tick();
      check("fin_hold_done", done, 1);
      check("fin_hold_step", step_out, LAST);

      // Mismatched done in step 2 is ignored; random latencies and decoys elsewhere
      go_pulse();
      run_step(1, 2, 1'b0);
      run_step(2, 4, 1'b1);
      for (int s = 3; s <= LAST; s++) begin
         d   = $urandom_range(1, TMO);
         dec = (d >= 2) && ($urandom_range(0, 1) == 1);
         run_step(s, d, dec);
      end
      do_reset();
      check_idle("post_run_rst");

      // Watchdog: no done in step 3
      go_pulse();
      run_step(1, 3, 1'b0);
      run_step(2, 3, 1'b0);
      check("tmo_comp_start", comp_start, 1);
      tick();
      for (int i = 1; i < TMO; i++) begin
         check("tmo_pre_busy", {busy, error}, 2'b10);
         tick();
      end
      check("tmo_last_wait", {busy, error}, 2'b10);
      tick();
      check("tmo_error", {error, busy, done}, 3'b100);
      check("tmo_step", step_out, 3);
      go = 1'b1;
      comp_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("err_go_ignored", {error, busy, load_start, comp_start}, 4'b1000);
         check("err_step", step_out, 3);
      end
      go = 1'b0;
      comp_done = 1'b0;
      do_reset();
      check_idle("err_rst");

      // Reset during WAIT of step 6, then restart
      go_pulse();
      for (int s = 1; s <= 5; s++) run_step(s, 2, 1'b0);
      check("pre_rst_step", step_out, 6);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_idle("mid_rst");
      rst = 1'b0;
      tick();
      check_idle("mid_rst_after");
      go_pulse();
      check("restart_step", step_out, 1);
      check("restart_load", load_start, 1);
      tick();
      do_reset();

      // GO held high through a run; done on the exact watchdog limit cycle
      go = 1'b1;
      tick();
      for (int s = 1; s <= LAST; s++) begin
         d = (s == 1 || s == 3) ? TMO : $urandom_range(1, 6);
         run_step(s, d, 1'b0);
      end
      tick();
      check("hold_restart_step", step_out, 1);
      check("hold_restart_load", load_start, 1);
      check("hold_restart_flags", {busy, done, error}, 3'b100);
      go = 1'b0;
      do_reset();
      check_idle("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
